// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction-memory blocks and the fetch-stage
// logic that talks to them: default geometry and the burst FSM encoding.
package instr_mem_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_LEN_WIDTH  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/instr_mem_array.sv
// Single-write, single-read synchronous RAM with a registered, read-first
// output. The output register only updates when rd_en is high, so it holds
// the last word read while the consumer stalls.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write port.
  // NOTE: the array is deliberately left out of reset so it maps onto RAM
  // macros; only the output register below is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; clears on reset, holds when no read is issued.
  // NOTE: non-blocking writes mean a same-edge read of a location being
  // written still sees the old word, which gives the read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instr_mem_burst.sv
// Burst-capable instruction memory. A request in IDLE issues the first read
// on the accepting edge (latency 1); BURST then streams sequential, wrapping
// words under a valid/ready handshake, issuing a new read only when the
// output register is empty or being drained this cycle.
module instr_mem_burst
  import instr_mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  req_ready,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_last
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;        // next word to read
  logic [LEN_WIDTH-1:0]  remaining;  // beats still to issue after the current one
  logic                  accept;
  logic                  issue;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  // Read-issue decode: first beat from the request port, later beats from ptr.
  // NOTE: every signal gets a value on every path so no latch is inferred.
  always_comb begin
    accept = (state == IDLE) && rd_req;
    issue  = (state == BURST) && (remaining != '0) && (!rd_valid || rd_ready);
    rd_en  = accept || issue;
    rd_ptr = accept ? rd_addr : ptr;
  end

  instr_mem_array #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Burst FSM with registered req_ready, rd_valid and rd_last.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      ptr       <= '0;
      remaining <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            state     <= BURST;
            req_ready <= 1'b0;
            ptr       <= rd_addr + 1'b1;
            remaining <= rd_len;
            rd_valid  <= 1'b1;
            rd_last   <= (rd_len == '0);
          end
        end
        BURST: begin
          if (issue) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            rd_valid  <= 1'b1;
            rd_last   <= (remaining == LEN_WIDTH'(1));
          end else if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (rd_valid && rd_last) begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_burst.sv
// Self-checking bench for instr_mem_burst: directed scenarios followed by
// randomized bursts, all checked against a word-array model of the memory.
module tb_instr_mem_burst;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int LW = 4;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_len;
  logic          req_ready;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic          rd_last;

  logic [W-1:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_burst #(.WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_len    (rd_len),
    .req_ready (req_ready),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int a, input logic [W-1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    model_mem[a] = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // One complete burst. Expected beats come from the model array; outputs are
  // sampled on the falling edge. Optional: fixed stall on one beat, random
  // rd_ready, a rd_req pulse mid-burst, and a same-edge write to the start
  // address (the burst must still see the old word).
  task automatic run_burst(input int addr, input int len, input int stall_beat,
                           input int stall_len, input bit rnd, input bit pulse,
                           input bit coll, input logic [W-1:0] coll_data);
    logic [W-1:0] exp_q[$];
    int idx, cycles, stalled;
    bit r;
    for (int i = 0; i <= len; i++) exp_q.push_back(model_mem[(addr + i) % DEPTH]);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    rd_req   = 1'b1;
    rd_addr  = addr[AW-1:0];
    rd_len   = len[LW-1:0];
    rd_ready = 1'b0;
    if (coll) begin
      wr_en   = 1'b1;
      wr_addr = addr[AW-1:0];
      wr_data = coll_data;
      model_mem[addr] = coll_data;
    end
    idx = 0; cycles = 0; stalled = 0;
    while (idx <= len && cycles < 200) begin
      @(negedge clk);
      cycles++;
      wr_en  = 1'b0;
      rd_req = pulse && (cycles == 2);
      if (pulse && cycles == 2) begin
        rd_addr = 5'd3;
        rd_len  = 4'd15;
      end
      check("beat_valid", rd_valid, 1);
      check("busy_req_ready", req_ready, 0);
      check($sformatf("beat%0d_data", idx), rd_data, exp_q[idx]);
      check($sformatf("beat%0d_last", idx), rd_last, (idx == len) ? 1 : 0);
      if (idx == stall_beat && stalled < stall_len) begin
        r = 1'b0;
        stalled++;
      end else if (rnd) begin
        r = ($urandom_range(0, 2) != 0);
      end else begin
        r = 1'b1;
      end
      rd_ready = r;
      if (r) idx++;
    end
    check("beats_done", idx, len + 1);
    check("burst_cycles", cycles, len + 1 + stalled + ((rnd) ? (cycles - len - 1 - stalled) : 0));
    @(negedge clk);
    rd_req   = 1'b0;
    rd_ready = 1'b0;
    check("post_req_ready", req_ready, 1);
    check("post_valid", rd_valid, 0);
    check("post_last", rd_last, 0);
    @(negedge clk);
    check("idle_valid", rd_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_data", rd_data, 0);
    rst_n = 1'b1;

    // Load then single read
    do_write(19, 32'h3762_35E0);
    run_burst(19, 0, -1, 0, 1'b0, 1'b0, 1'b0, '0);

    // mem[i] = i
    for (int i = 0; i < DEPTH; i++) do_write(i, W'(i));

    // Wrap burst, then the same burst with a 3-cycle stall on beat 2
    run_burst(30, 3, -1, 0, 1'b0, 1'b0, 1'b0, '0);
    run_burst(30, 3, 1, 3, 1'b0, 1'b0, 1'b0, '0);

    // Read-first collision, then the new word on a later burst
    do_write(7, 32'hAAAA_0007);
    run_burst(7, 0, -1, 0, 1'b0, 1'b0, 1'b1, 32'hBBBB_0007);
    run_burst(7, 0, -1, 0, 1'b0, 1'b0, 1'b0, '0);

    // Reset during beat 2 of a 16-beat burst
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 5'd0; rd_len = 4'd15; rd_ready = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("pre_rst_beat1", rd_data, model_mem[0]);
    @(negedge clk);
    check("pre_rst_beat2", rd_data, model_mem[1]);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_ready = 1'b0;
    check("midrst_valid", rd_valid, 0);
    check("midrst_last", rd_last, 0);
    check("midrst_data", rd_data, 0);
    check("midrst_req_ready", req_ready, 1);
    run_burst(12, 5, -1, 0, 1'b0, 1'b0, 1'b0, '0);

    // Request while busy is ignored
    run_burst(20, 7, -1, 0, 1'b0, 1'b1, 1'b0, '0);

    // Randomized traffic
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 1) == 1) do_write($urandom_range(0, DEPTH - 1), $urandom);
      run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 3), 1'b1, 1'b0, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
